// File: rtl/conv_mem_host.sv
// Host-side memory subsystem for a convolution engine.
// Holds the input image, the L0 and L1 layer result memories, and sequences one session:
// image load -> arm engine -> serve engine memory traffic -> dump results.
//
// Ports
//   clk, reset                        clock, asynchronous active-high reset
//   start_i                           begin a session (accepted in idle/done only)
//   ld_valid_i, ld_data_i, ld_ready_o image load stream
//   ready_o, busy_i                   request to / activity flag from the engine
//   iaddr_i, idata_o                  engine image read port (asynchronous)
//   cwr_i, caddr_wr_i, cdata_wr_i     engine layer write port
//   crd_i, caddr_rd_i, cdata_rd_o     engine layer read port (asynchronous)
//   csel_i                            layer select: 1 = L0, 3 = L1
//   dp_valid_o, dp_data_o, dp_last_o, dp_ready_i  result dump stream (L0 then L1)
//   done_o, err_o, cyc_cnt_o          session done, sticky error, engine cycle count
module conv_mem_host #(
  parameter int unsigned IMG_WORDS = 4096,
  parameter int unsigned L1_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        ld_valid_i,
  input  logic [19:0] ld_data_i,
  output logic        ld_ready_o,
  output logic        ready_o,
  input  logic        busy_i,
  input  logic [11:0] iaddr_i,
  output logic [19:0] idata_o,
  input  logic        cwr_i,
  input  logic [11:0] caddr_wr_i,
  input  logic [19:0] cdata_wr_i,
  input  logic        crd_i,
  input  logic [11:0] caddr_rd_i,
  input  logic [2:0]  csel_i,
  output logic [19:0] cdata_rd_o,
  output logic        dp_valid_o,
  output logic [19:0] dp_data_o,
  output logic        dp_last_o,
  input  logic        dp_ready_i,
  output logic        done_o,
  output logic        err_o,
  output logic [19:0] cyc_cnt_o
);

  localparam logic [11:0] LdLast = 12'(IMG_WORDS - 1);
  localparam logic [12:0] DpLast = 13'(IMG_WORDS + L1_WORDS - 1);
  localparam logic [12:0] L1Base = 13'(IMG_WORDS);

  typedef enum logic [2:0] {StIdle, StLoad, StArm, StServe, StDump, StDone} state_e;

  state_e      state_q, state_d;
  logic [11:0] ld_cnt_q, ld_cnt_d;
  logic [12:0] dp_cnt_q, dp_cnt_d;
  logic [19:0] cyc_cnt_q, cyc_cnt_d;
  logic        err_q, err_d;

  logic [19:0] img_mem [IMG_WORDS];
  logic [19:0] l0_mem  [IMG_WORDS];
  logic [19:0] l1_mem  [L1_WORDS];

  logic        sel_l0, sel_l1, bad_sel, bad_l1_addr, bad_state;
  logic        img_wr, l0_wr, l1_wr;
  logic [9:0]  l1_dump_idx;
  logic [19:0] cyc_inc;

  assign sel_l0      = (csel_i == 3'd1);
  assign sel_l1      = (csel_i == 3'd3);
  assign bad_sel     = (cwr_i | crd_i) & ~(sel_l0 | sel_l1);
  assign bad_l1_addr = cwr_i & sel_l1 & (caddr_wr_i[11:10] != 2'b00);
  assign bad_state   = cwr_i & (state_q != StServe);

  // Illegal writes are dropped, not just flagged.
  assign img_wr = (state_q == StLoad) & ld_valid_i;
  assign l0_wr  = (state_q == StServe) & cwr_i & sel_l0;
  assign l1_wr  = (state_q == StServe) & cwr_i & sel_l1 & (caddr_wr_i[11:10] == 2'b00);

  assign cyc_inc = (cyc_cnt_q == 20'hFFFFF) ? cyc_cnt_q : cyc_cnt_q + 20'd1;

  // Memories: asynchronous read, write at the clock edge, never reset.
  always_ff @(posedge clk) begin
    if (img_wr) img_mem[ld_cnt_q] <= ld_data_i;
  end

  always_ff @(posedge clk) begin
    if (l0_wr) l0_mem[caddr_wr_i] <= cdata_wr_i;
  end

  always_ff @(posedge clk) begin
    if (l1_wr) l1_mem[caddr_wr_i[9:0]] <= cdata_wr_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ld_cnt_q  <= '0;
      dp_cnt_q  <= '0;
      cyc_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      dp_cnt_q  <= dp_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    dp_cnt_d  = dp_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    err_d     = err_q | bad_sel | bad_l1_addr | bad_state;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d  = StLoad;
          ld_cnt_d = '0;
          err_d    = 1'b0;
        end
      end
      StLoad: begin
        if (ld_valid_i) begin
          ld_cnt_d = ld_cnt_q + 12'd1;
          if (ld_cnt_q == LdLast) begin
            state_d   = StArm;
            cyc_cnt_d = '0;
          end
        end
      end
      StArm: begin
        cyc_cnt_d = cyc_inc;
        if (busy_i) state_d = StServe;
      end
      StServe: begin
        cyc_cnt_d = cyc_inc;
        if (!busy_i) begin
          state_d  = StDump;
          dp_cnt_d = '0;
        end
      end
      StDump: begin
        if (dp_ready_i) begin
          if (dp_cnt_q == DpLast) state_d = StDone;
          else                    dp_cnt_d = dp_cnt_q + 13'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign l1_dump_idx = 10'(dp_cnt_q - L1Base);

  always_comb begin
    cdata_rd_o = '0;
    if (crd_i && sel_l0)      cdata_rd_o = l0_mem[caddr_rd_i];
    else if (crd_i && sel_l1) cdata_rd_o = l1_mem[caddr_rd_i[9:0]];
  end

  assign idata_o    = img_mem[iaddr_i];
  assign dp_data_o  = (dp_cnt_q < L1Base) ? l0_mem[dp_cnt_q[11:0]] : l1_mem[l1_dump_idx];
  assign ld_ready_o = (state_q == StLoad);
  assign ready_o    = (state_q == StArm);
  assign dp_valid_o = (state_q == StDump);
  assign dp_last_o  = (state_q == StDump) && (dp_cnt_q == DpLast);
  assign done_o     = (state_q == StDone);
  assign err_o      = err_q;
  assign cyc_cnt_o  = cyc_cnt_q;

endmodule

// File: tb/tb_conv_mem_host.sv
// Self-checking bench for conv_mem_host: a session-level model (phase, memory images,
// handshake index, error and cycle rules) is checked every cycle on the falling edge,
// plus literal expectations at the key points of each session.
module tb_conv_mem_host;

  logic        clk, reset;
  logic        start, ld_valid, ld_ready, ready, busy;
  logic [19:0] ld_data, idata, cdata_wr, cdata_rd, dp_data, cyc_cnt;
  logic [11:0] iaddr, caddr_wr, caddr_rd;
  logic        cwr, crd, dp_valid, dp_last, dp_ready, done, err;
  logic [2:0]  csel;

  conv_mem_host dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .ld_valid_i (ld_valid),
    .ld_data_i  (ld_data),
    .ld_ready_o (ld_ready),
    .ready_o    (ready),
    .busy_i     (busy),
    .iaddr_i    (iaddr),
    .idata_o    (idata),
    .cwr_i      (cwr),
    .caddr_wr_i (caddr_wr),
    .cdata_wr_i (cdata_wr),
    .crd_i      (crd),
    .caddr_rd_i (caddr_rd),
    .csel_i     (csel),
    .cdata_rd_o (cdata_rd),
    .dp_valid_o (dp_valid),
    .dp_data_o  (dp_data),
    .dp_last_o  (dp_last),
    .dp_ready_i (dp_ready),
    .done_o     (done),
    .err_o      (err),
    .cyc_cnt_o  (cyc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {PhIdle, PhLoad, PhArm, PhServe, PhDump, PhDone} ph_e;

  int          total = 0;
  int          bad = 0;
  ph_e         ph, prev_ph;
  logic [19:0] img_m [4096];
  logic [19:0] l0_m  [4096];
  logic [19:0] l1_m  [1024];
  bit          img_k [4096];
  bit          l0_k  [4096];
  bit          l1_k  [1024];
  int          ld_idx, hs_idx;
  logic        exp_err;
  logic [19:0] exp_cyc;
  logic        stalled;
  logic [19:0] prev_dp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the session model, then advance the model by the
  // inputs the coming rising edge will see.
  task automatic monitor();
    logic [19:0] exp_dp;
    if (reset) begin
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_ready", ready, 0);
      chk("rst_dp_valid", dp_valid, 0);
      chk("rst_dp_last", dp_last, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_cyc", cyc_cnt, 0);
      exp_err = 1'b0;
      exp_cyc = '0;
      prev_ph = PhIdle;
      stalled = 1'b0;
      return;
    end
    if (ph == PhLoad && prev_ph != PhLoad) begin
      exp_err = 1'b0;
      ld_idx  = 0;
    end
    if (ph == PhArm && prev_ph == PhLoad) exp_cyc = '0;
    if (ph == PhDump && prev_ph != PhDump) begin
      hs_idx  = 0;
      stalled = 1'b0;
    end

    chk("ld_ready", ld_ready, ph == PhLoad);
    chk("ready", ready, ph == PhArm);
    chk("dp_valid", dp_valid, ph == PhDump);
    chk("done", done, ph == PhDone);
    chk("err", err, exp_err);
    chk("cyc_cnt", cyc_cnt, exp_cyc);
    if (img_k[iaddr]) chk("idata", idata, img_m[iaddr]);
    if (!crd) chk("cdata_rd_idle", cdata_rd, 0);
    else if (csel == 3'd1 && l0_k[caddr_rd]) chk("cdata_rd_l0", cdata_rd, l0_m[caddr_rd]);
    else if (csel == 3'd3 && l1_k[caddr_rd[9:0]])
      chk("cdata_rd_l1", cdata_rd, l1_m[caddr_rd[9:0]]);
    else if (csel != 3'd1 && csel != 3'd3) chk("cdata_rd_badsel", cdata_rd, 0);

    if (ph == PhDump && hs_idx < 5120) begin
      exp_dp = (hs_idx < 4096) ? l0_m[hs_idx] : l1_m[hs_idx - 4096];
      chk("dp_data", dp_data, exp_dp);
      chk("dp_last", dp_last, hs_idx == 5119);
      if (stalled) chk("dp_stable", dp_data, prev_dp);
    end else begin
      chk("dp_last_off", dp_last, 0);
    end

    if (((cwr || crd) && csel != 3'd1 && csel != 3'd3) ||
        (cwr && csel == 3'd3 && caddr_wr[11:10] != 2'b00) ||
        (cwr && ph != PhServe))
      exp_err = 1'b1;
    if (ph == PhServe && cwr && csel == 3'd1) begin
      l0_m[caddr_wr] = cdata_wr;
      l0_k[caddr_wr] = 1'b1;
    end
    if (ph == PhServe && cwr && csel == 3'd3 && caddr_wr[11:10] == 2'b00) begin
      l1_m[caddr_wr[9:0]] = cdata_wr;
      l1_k[caddr_wr[9:0]] = 1'b1;
    end
    if (ph == PhLoad && ld_valid) begin
      img_m[ld_idx[11:0]] = ld_data;
      img_k[ld_idx[11:0]] = 1'b1;
      ld_idx = (ld_idx + 1) % 4096;
    end
    if (ph == PhDump) begin
      stalled = !dp_ready;
      prev_dp = dp_data;
      if (dp_ready) hs_idx++;
    end
    if ((ph == PhArm || ph == PhServe) && exp_cyc != 20'hFFFFF) exp_cyc = exp_cyc + 20'd1;
    prev_ph = ph;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    bit seen_last;
    reset = 1'b1; start = 0; ld_valid = 0; ld_data = '0; busy = 0; iaddr = '0;
    cwr = 0; caddr_wr = '0; cdata_wr = '0; crd = 0; caddr_rd = '0; csel = '0; dp_ready = 0;
    ph = PhIdle; prev_ph = PhIdle; ld_idx = 0; hs_idx = 0; exp_err = 0; exp_cyc = '0;
    stalled = 0; prev_dp = '0;
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // Write outside SERVE: flagged and dropped.
    cwr = 1; csel = 3'd1; caddr_wr = 12'h005; cdata_wr = 20'hBAD00;
    step();
    cwr = 0;
    chk("err_idle_wr", err, 1);
    step();

    // Session 1: ramp load.
    start = 1;
    step();
    start = 0; ph = PhLoad;
    chk("err_clr_on_load", err, 0);
    for (int i = 0; i < 4096; i++) begin
      ld_valid = 1; ld_data = 20'(i);
      step();
    end
    ld_valid = 0; ph = PhArm;
    chk("ready_after_load", ready, 1);
    iaddr = 12'hABC;
    #1 chk("idata_abc", idata, 20'h00ABC);
    repeat (3) step();
    busy = 1;
    step();
    ph = PhServe;
    chk("ready_drop", ready, 0);
    start = 1;
    step();
    start = 0;

    // Fill both layer memories.
    for (int i = 0; i < 4096; i++) begin
      cwr = 1; csel = 3'd1; caddr_wr = 12'(i); cdata_wr = 20'(i) ^ 20'h5A5A5;
      step();
    end
    for (int j = 0; j < 1024; j++) begin
      cwr = 1; csel = 3'd3; caddr_wr = 12'(j); cdata_wr = 20'h80000 + 20'(j * 3);
      step();
    end
    cwr = 1; csel = 3'd1; caddr_wr = 12'h005; cdata_wr = 20'h12345;
    step();
    csel = 3'd3; caddr_wr = 12'h3FF; cdata_wr = 20'h0F0F0;
    step();
    cwr = 0; crd = 1; csel = 3'd1; caddr_rd = 12'h005;
    #1 chk("rd_l0_5", cdata_rd, 20'h12345);
    cwr = 1; caddr_wr = 12'h005; cdata_wr = 20'h54321;
    #1 chk("rd_during_wr_old", cdata_rd, 20'h12345);
    step();
    cwr = 0;
    #1 chk("rd_after_wr_new", cdata_rd, 20'h54321);
    cwr = 1; cdata_wr = 20'h12345;
    step();
    cwr = 0; crd = 0;
    chk("err_clean_serve", err, 0);

    // Bad select write, bad-select read, out-of-range L1 write.
    csel = 3'd2; cwr = 1; caddr_wr = 12'h005; cdata_wr = 20'hBAD11;
    step();
    cwr = 0;
    chk("err_bad_sel", err, 1);
    csel = 3'd1; crd = 1; caddr_rd = 12'h005;
    #1 chk("l0_unchanged", cdata_rd, 20'h12345);
    csel = 3'd0;
    #1 chk("rd_sel0_zero", cdata_rd, 20'h00000);
    crd = 0; csel = 3'd3; cwr = 1; caddr_wr = 12'h7FF; cdata_wr = 20'hDEAD5;
    step();
    cwr = 0; crd = 1; caddr_rd = 12'h3FF;
    #1 chk("l1_alias_dropped", cdata_rd, 20'h0F0F0);
    step();
    crd = 0; csel = 3'd0; busy = 0;
    step();
    ph = PhDump;
    chk("dump_valid", dp_valid, 1);

    // Dump with dp_ready pattern 1,0,0,1.
    k = 0; seen_last = 0;
    while (ph == PhDump) begin
      if (hs_idx == 5119 && !seen_last) begin
        chk("dump_5119_data", dp_data, 20'h0F0F0);
        chk("dump_5119_last", dp_last, 1);
        seen_last = 1;
      end
      dp_ready = (k % 4 == 0) || (k % 4 == 3);
      k++;
      step();
      if (hs_idx == 5120) ph = PhDone;
    end
    dp_ready = 0;
    chk("done_after_dump", done, 1);
    chk("done_dp_valid", dp_valid, 0);
    repeat (3) step();
    cwr = 1; csel = 3'd1; caddr_wr = 12'h005; cdata_wr = 20'hBAD22;
    step();
    cwr = 0;
    chk("err_done_wr", err, 1);
    crd = 1;
    caddr_rd = 12'h005;
    #1 chk("l0_after_done_wr", cdata_rd, 20'h12345);
    step();
    crd = 0;

    // Session 2: inverted load, short serve, reset mid-dump.
    start = 1;
    step();
    start = 0; ph = PhLoad;
    chk("err_clr_s2", err, 0);
    for (int i = 0; i < 4096; i++) begin
      ld_valid = 1; ld_data = 20'hFFFFF ^ 20'(i);
      step();
    end
    ld_valid = 0; ph = PhArm; busy = 1;
    step();
    ph = PhServe;
    cwr = 1; csel = 3'd1; caddr_wr = 12'h007; cdata_wr = 20'h77777;
    step();
    cwr = 0; busy = 0;
    step();
    ph = PhDump; dp_ready = 1;
    while (hs_idx < 100) step();
    reset = 1'b1;
    #1;
    chk("rst_dump_valid", dp_valid, 0);
    chk("rst_dump_last", dp_last, 0);
    chk("rst_dump_cyc", cyc_cnt, 0);
    chk("rst_dump_done", done, 0);
    ph = PhIdle;
    repeat (2) step();
    reset = 1'b0; dp_ready = 0;
    repeat (2) step();

    // Session 3: reload start, layer memories retained.
    start = 1;
    step();
    start = 0; ph = PhLoad;
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1; ld_data = 20'h33300 + 20'(i);
      step();
    end
    ld_valid = 0; crd = 1; csel = 3'd1; caddr_rd = 12'h005;
    #1 chk("l0_retained_5", cdata_rd, 20'h12345);
    caddr_rd = 12'h007;
    #1 chk("l0_retained_7", cdata_rd, 20'h77777);
    iaddr = 12'h003;
    #1 chk("idata_reload", idata, 20'h33303);
    iaddr = 12'hABC;
    #1 chk("idata_old_s2", idata, 20'hFF543);
    step();
    crd = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_mem_host.md
CONV_MEM_HOST -- requirements
Module: conv_mem_host

Interface
REQ-001 SHALL have ports: clk input 1 system clock; reset input 1 asynchronous, active-high reset.
REQ-002 SHALL have ports: start input 1 (begin session pulse); ld_valid input 1; ld_data input 20; ld_ready output 1 (image load stream).
REQ-003 SHALL have ports: ready output 1 (request to CONV engine); busy input 1 (engine activity flag).
REQ-004 SHALL have ports: iaddr input 12 (image read address); idata output 20 (image pixel).
REQ-005 SHALL have ports: cwr input 1, caddr_wr input 12, cdata_wr input 20, crd input 1, caddr_rd input 12, csel input 3 (layer memory requests); cdata_rd output 20.
REQ-006 SHALL have ports: dp_valid output 1, dp_data output 20, dp_last output 1, dp_ready input 1 (result dump stream); done output 1; err output 1; cyc_cnt output 20.
REQ-007 SHALL have parameters: IMG_WORDS default 4096 (image/L0 depth); L1_WORDS default 1024 (L1 depth).

Function
REQ-008 SHALL contain image RAM (4096x20), L0 RAM (4096x20, csel=1), L1 RAM (1024x20, csel=3, addressed by caddr[9:0]).
REQ-009 SHALL implement FSM IDLE, LOAD, ARM, SERVE, DUMP, DONE; reset state IDLE.
REQ-010 IDLE/DONE -> LOAD on start=1; start SHALL be ignored in all other states.
REQ-011 LOAD: ld_ready=1; each cycle with ld_valid=1 writes ld_data to image[ld_cnt] and increments 12-bit ld_cnt from 0; acceptance of word 4095 -> ARM.
REQ-012 ARM: ready=1 combinationally from state; first cycle busy=1 is sampled -> SERVE; ready=0 from the next cycle.
REQ-013 SERVE: busy sampled 0 -> DUMP; cyc_cnt cleared on LOAD->ARM, incremented every ARM and SERVE cycle, saturating at 0xFFFFF.
REQ-014 idata SHALL equal image[iaddr] combinationally (asynchronous read, valid the same cycle iaddr changes) in every state.
REQ-015 cdata_rd SHALL equal combinationally L0[caddr_rd] when crd=1 and csel=1, L1[caddr_rd[9:0]] when crd=1 and csel=3, else 0.
REQ-016 On clock edge with cwr=1 in SERVE: csel=1 writes cdata_wr to L0[caddr_wr]; csel=3 writes to L1[caddr_wr[9:0]].
REQ-017 Same-cycle write and read of the same location SHALL return the old data on cdata_rd (write takes effect at the edge).
REQ-018 err SHALL set (sticky until reset or LOAD entry) on: cwr=1 or crd=1 with csel not in {1,3}; cwr=1 with csel=3 and caddr_wr[11:10]!=0; cwr=1 outside SERVE; such writes SHALL be discarded.
REQ-019 DUMP: 13-bit dp_cnt from 0 to 5119; dp_valid=1; dp_data = L0[dp_cnt] for dp_cnt<4096, else L1[dp_cnt-4096]; dp_cnt advances only when dp_valid and dp_ready both 1.
REQ-020 dp_data SHALL remain stable while dp_valid=1 and dp_ready=0; dp_last=1 exactly when dp_cnt=5119.
REQ-021 Handshake on dp_cnt=5119 -> DONE; DONE: done=1, dp_valid=0, cyc_cnt held.
REQ-022 ld_ready, ready, dp_valid SHALL be 0 outside LOAD, ARM, DUMP respectively.

Reset
REQ-023 Asynchronous reset SHALL force state IDLE, ld_cnt=0, dp_cnt=0, cyc_cnt=0, err=0, done=0, and ready, ld_ready, dp_valid, dp_last to 0.
REQ-024 RAM contents SHALL NOT be cleared by reset; reset mid-LOAD/SERVE/DUMP SHALL abort to IDLE with no further writes.
REQ-025 reset deasserted: first action only after start=1.

Verification
REQ-026 Load ramp image[i]=i (ld_valid always 1) -> ld_ready high 4096 cycles, then ready=1; idata=0x00ABC when iaddr=0xABC, same cycle.
REQ-027 ARM, busy raised at cycle N -> ready=0 from N+1; busy falls -> dp_valid=1 next cycle, dp_cnt=0.
REQ-028 SERVE: cwr csel=1 caddr_wr=0x005 data 0x12345, then crd csel=1 caddr_rd=0x005 -> cdata_rd=0x12345; csel=3 caddr 0x3FF data 0x0F0F0 -> dump word 5119 = 0x0F0F0 with dp_last=1.
REQ-029 cwr with csel=2 -> err=1, no RAM changed; crd with csel=0 -> cdata_rd=0.
REQ-030 Dump with dp_ready toggling 1,0,0,1 -> dp_data stable during stalls; exactly 5120 handshakes then done=1.
REQ-031 Assert reset during DUMP at dp_cnt=100 -> dp_valid=0 immediately, state IDLE; new start reloads and prior L0 contents remain until overwritten.
